// File: rtl/ptp_pkg.sv
// Shared constants and types for the PTP receive event extractor.
// Byte offsets count from the first byte of the Ethernet destination address.
package ptp_pkg;

  localparam logic [15:0] PTP_ETHERTYPE_DEFAULT = 16'h88F7;

  localparam logic [3:0] MSG_SYNC        = 4'd0;
  localparam logic [3:0] MSG_DELAY_REQ   = 4'd1;
  localparam logic [3:0] MSG_PDELAY_REQ  = 4'd2;
  localparam logic [3:0] MSG_PDELAY_RESP = 4'd3;
  localparam logic [3:0] MSG_FOLLOW_UP   = 4'd8;

  localparam logic [5:0] ETYPE_OFS   = 6'd12;
  localparam logic [5:0] PTP_HDR_OFS = 6'd14;
  localparam logic [5:0] SEQ_OFS     = 6'd44;

  typedef enum logic [1:0] {
    ST_PARSE   = 2'd0,
    ST_WAIT_TS = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

endpackage

// File: rtl/ptp_rx_event_extract_if.sv
// Frame, timestamp and record handshake bundle of the PTP receive event extractor.
// The slave modport is the extractor; the master modport is its surroundings.
interface ptp_rx_event_extract_if #(
  parameter int PTP_TS_WIDTH = 96
) ();

  logic [7:0]              s_axis_tdata;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic                    s_axis_tlast;
  logic                    s_axis_tuser;
  logic [PTP_TS_WIDTH-1:0] s_axis_ts_96;
  logic                    s_axis_ts_valid;
  logic                    s_axis_ts_ready;
  logic [3:0]              m_ptp_msg_type;
  logic [15:0]             m_ptp_seq_id;
  logic [PTP_TS_WIDTH-1:0] m_ptp_ts_96;
  logic                    m_ptp_valid;
  logic                    m_ptp_ready;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output s_axis_ts_96, s_axis_ts_valid, m_ptp_ready,
    input  s_axis_tready, s_axis_ts_ready,
    input  m_ptp_msg_type, m_ptp_seq_id, m_ptp_ts_96, m_ptp_valid
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  s_axis_ts_96, s_axis_ts_valid, m_ptp_ready,
    output s_axis_tready, s_axis_ts_ready,
    output m_ptp_msg_type, m_ptp_seq_id, m_ptp_ts_96, m_ptp_valid
  );

endinterface

// File: rtl/ptp_hdr_capture.sv
// Counts accepted frame bytes, captures EtherType/messageType/sequenceId and
// latches whether the frame just ended qualifies as a recordable PTP event.
module ptp_hdr_capture
  import ptp_pkg::*;
#(
  parameter logic [15:0] PTP_ETHERTYPE = PTP_ETHERTYPE_DEFAULT,
  parameter logic [15:0] EVENT_MASK    = 16'h000F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        beat,
  input  logic [7:0]  data,
  input  logic        last,
  input  logic        user,
  output logic [3:0]  msg_type,
  output logic [15:0] seq_id,
  output logic        qualify
);

  logic [5:0]  cnt_reg;
  logic [15:0] etype_reg;
  logic [3:0]  type_reg;
  logic [15:0] seq_reg;
  logic        seq_seen_reg;
  logic        qualify_reg;
  logic        long_enough;
  logic        qualify_next;

  // The tlast beat itself may be the sequenceId low byte, so look at the counter too.
  always_comb begin
    long_enough  = seq_seen_reg || (cnt_reg == SEQ_OFS + 6'd1);
    qualify_next = (etype_reg == PTP_ETHERTYPE) && long_enough && !user
                   && EVENT_MASK[type_reg];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      etype_reg    <= '0;
      type_reg     <= '0;
      seq_reg      <= '0;
      seq_seen_reg <= 1'b0;
      qualify_reg  <= 1'b0;
    end else if (beat) begin
      case (cnt_reg)
        ETYPE_OFS:          etype_reg[15:8] <= data;
        ETYPE_OFS + 6'd1:   etype_reg[7:0]  <= data;
        PTP_HDR_OFS:        type_reg        <= data[3:0];
        SEQ_OFS:            seq_reg[15:8]   <= data;
        SEQ_OFS + 6'd1:     seq_reg[7:0]    <= data;
        default: ;
      endcase
      if (last) begin
        cnt_reg      <= '0;
        seq_seen_reg <= 1'b0;
        qualify_reg  <= qualify_next;
      end else begin
        if (cnt_reg != 6'd63) cnt_reg <= cnt_reg + 6'd1;
        if (cnt_reg == SEQ_OFS + 6'd1) seq_seen_reg <= 1'b1;
      end
    end
  end

  assign msg_type = type_reg;
  assign seq_id   = seq_reg;
  assign qualify  = qualify_reg;

endmodule

// File: rtl/ptp_rx_event_extract.sv
// Pairs each received frame with its rx timestamp and emits one record per
// qualifying PTP event message; all other timestamps are consumed and dropped.
module ptp_rx_event_extract
  import ptp_pkg::*;
#(
  parameter int          PTP_TS_WIDTH  = 96,
  parameter logic [15:0] PTP_ETHERTYPE = PTP_ETHERTYPE_DEFAULT,
  parameter logic [15:0] EVENT_MASK    = 16'h000F,
  parameter int          STAT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ptp_rx_event_extract_if.slave bus,
  output logic [STAT_WIDTH-1:0] stat_ptp_events,
  output logic [STAT_WIDTH-1:0] stat_dropped
);

  state_t                  state_reg;
  logic [3:0]              type_reg;
  logic [15:0]             seq_reg;
  logic [PTP_TS_WIDTH-1:0] ts_reg;
  logic                    valid_reg;
  logic                    beat;
  logic [3:0]              cap_type;
  logic [15:0]             cap_seq;
  logic                    cap_qualify;

  assign bus.s_axis_tready   = (state_reg == ST_PARSE);
  assign bus.s_axis_ts_ready = (state_reg == ST_WAIT_TS);
  assign beat = bus.s_axis_tvalid && (state_reg == ST_PARSE);

  ptp_hdr_capture #(
    .PTP_ETHERTYPE (PTP_ETHERTYPE),
    .EVENT_MASK    (EVENT_MASK)
  ) u_capture (
    .clk      (clk),
    .rst      (rst),
    .beat     (beat),
    .data     (bus.s_axis_tdata),
    .last     (bus.s_axis_tlast),
    .user     (bus.s_axis_tuser),
    .msg_type (cap_type),
    .seq_id   (cap_seq),
    .qualify  (cap_qualify)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_PARSE;
      type_reg        <= '0;
      seq_reg         <= '0;
      ts_reg          <= '0;
      valid_reg       <= 1'b0;
      stat_ptp_events <= '0;
      stat_dropped    <= '0;
    end else begin
      case (state_reg)
        ST_PARSE: begin
          if (beat && bus.s_axis_tlast) state_reg <= ST_WAIT_TS;
        end
        ST_WAIT_TS: begin
          if (bus.s_axis_ts_valid) begin
            if (cap_qualify) begin
              type_reg  <= cap_type;
              seq_reg   <= cap_seq;
              ts_reg    <= bus.s_axis_ts_96;
              valid_reg <= 1'b1;
              state_reg <= ST_OUTPUT;
            end else begin
              stat_dropped <= stat_dropped + 1'b1;
              state_reg    <= ST_PARSE;
            end
          end
        end
        ST_OUTPUT: begin
          if (bus.m_ptp_ready) begin
            valid_reg       <= 1'b0;
            stat_ptp_events <= stat_ptp_events + 1'b1;
            state_reg       <= ST_PARSE;
          end
        end
        default: state_reg <= ST_PARSE;
      endcase
    end
  end

  assign bus.m_ptp_msg_type = type_reg;
  assign bus.m_ptp_seq_id   = seq_reg;
  assign bus.m_ptp_ts_96    = ts_reg;
  assign bus.m_ptp_valid    = valid_reg;

endmodule

// File: tb/tb_ptp_rx_event_extract.sv
// Directed plus randomized frames against a frame-level reference model; two
// instances differ only in EVENT_MASK and are selected one at a time.
module tb_ptp_rx_event_extract;
  import ptp_pkg::*;

  typedef logic [7:0] byte_q[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [7:0]  tdata = '0;
  logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic [95:0] ts = '0;
  logic        ts_valid = 1'b0;
  logic        m_ready = 1'b1;
  logic [15:0] stat_ev0, stat_dr0, stat_ev1, stat_dr1;

  int n_checks = 0;
  int n_fail   = 0;
  int ev[2] = '{0, 0};
  int dr[2] = '{0, 0};

  always #5 clk = ~clk;

  ptp_rx_event_extract_if #(.PTP_TS_WIDTH(96)) if0 ();
  ptp_rx_event_extract_if #(.PTP_TS_WIDTH(96)) if1 ();

  assign if0.s_axis_tdata    = tdata;
  assign if0.s_axis_tvalid   = tvalid & ~sel;
  assign if0.s_axis_tlast    = tlast;
  assign if0.s_axis_tuser    = tuser;
  assign if0.s_axis_ts_96    = ts;
  assign if0.s_axis_ts_valid = ts_valid & ~sel;
  assign if0.m_ptp_ready     = m_ready | sel;
  assign if1.s_axis_tdata    = tdata;
  assign if1.s_axis_tvalid   = tvalid & sel;
  assign if1.s_axis_tlast    = tlast;
  assign if1.s_axis_tuser    = tuser;
  assign if1.s_axis_ts_96    = ts;
  assign if1.s_axis_ts_valid = ts_valid & sel;
  assign if1.m_ptp_ready     = m_ready | ~sel;

  ptp_rx_event_extract #(.EVENT_MASK(16'h000F)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .stat_ptp_events(stat_ev0), .stat_dropped(stat_dr0));
  ptp_rx_event_extract #(.EVENT_MASK(16'h010F)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .stat_ptp_events(stat_ev1), .stat_dropped(stat_dr1));

  wire        cur_tready   = sel ? if1.s_axis_tready   : if0.s_axis_tready;
  wire        cur_ts_ready = sel ? if1.s_axis_ts_ready : if0.s_axis_ts_ready;
  wire        cur_mvalid   = sel ? if1.m_ptp_valid     : if0.m_ptp_valid;
  wire [3:0]  cur_mtype    = sel ? if1.m_ptp_msg_type  : if0.m_ptp_msg_type;
  wire [15:0] cur_mseq     = sel ? if1.m_ptp_seq_id    : if0.m_ptp_seq_id;
  wire [95:0] cur_mts      = sel ? if1.m_ptp_ts_96     : if0.m_ptp_ts_96;
  wire [15:0] cur_stat_ev  = sel ? stat_ev1 : stat_ev0;
  wire [15:0] cur_stat_dr  = sel ? stat_dr1 : stat_dr0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic byte_q make_frame(input int len, input logic [15:0] et,
                                       input logic [3:0] mt, input logic [15:0] sq);
    byte_q f;
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      if (i == 12) b = et[15:8];
      if (i == 13) b = et[7:0];
      if (i == 14) b = {b[7:4], mt};
      if (i == 44) b = sq[15:8];
      if (i == 45) b = sq[7:0];
      f.push_back(b);
    end
    return f;
  endfunction

  // Reference: a record is due only for a complete, good, long-enough PTP event frame.
  function automatic logic model_qual(input byte_q f, input logic tu, input logic [15:0] mask);
    logic [7:0] b14;
    if (f.size() < 46) return 1'b0;
    if ({f[12], f[13]} != 16'h88F7) return 1'b0;
    if (tu) return 1'b0;
    b14 = f[14];
    return mask[b14[3:0]];
  endfunction

  task automatic wait_ready(input string tag, input logic want_ts);
    int n = 0;
    while (((want_ts ? cur_ts_ready : cur_tready) !== 1'b1) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) check({tag, "_ready_timeout"}, 128'(n), 128'(0));
  endtask

  task automatic send_frame(input string tag, input byte_q f, input logic tu);
    for (int i = 0; i < f.size(); i++) begin
      tdata  = f[i];
      tvalid = 1'b1;
      tlast  = (i == f.size() - 1);
      tuser  = tlast ? tu : 1'($urandom);
      wait_ready(tag, 1'b0);
      tick();
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
  endtask

  task automatic run_frame(input string tag, input byte_q f, input logic tu,
                           input logic [95:0] tsv, input int ts_delay);
    logic q;
    logic [7:0] b14;
    int s;
    s = sel ? 1 : 0;
    q = model_qual(f, tu, sel ? 16'h010F : 16'h000F);
    send_frame(tag, f, tu);
    check({tag, "_rdy_after_last"}, 128'({cur_tready, cur_ts_ready}), 128'(2'b01));
    repeat (ts_delay) tick();
    ts = tsv;
    ts_valid = 1'b1;
    wait_ready(tag, 1'b1);
    tick();
    ts_valid = 1'b0;
    check({tag, "_valid"}, 128'(cur_mvalid), 128'(q));
    if (q) begin
      b14 = f[14];
      check({tag, "_type"}, 128'(cur_mtype), 128'(b14[3:0]));
      check({tag, "_seq"}, 128'(cur_mseq), 128'({f[44], f[45]}));
      check({tag, "_ts"}, 128'(cur_mts), 128'(tsv));
      check({tag, "_tready_out"}, 128'(cur_tready), 128'(0));
      if (m_ready) begin
        tick();
        ev[s]++;
        check({tag, "_valid_drop"}, 128'(cur_mvalid), 128'(0));
        check({tag, "_stat_ev"}, 128'(cur_stat_ev), 128'(16'(ev[s])));
        check({tag, "_tready_back"}, 128'(cur_tready), 128'(1));
      end
    end else begin
      dr[s]++;
      check({tag, "_stat_dr"}, 128'(cur_stat_dr), 128'(16'(dr[s])));
      check({tag, "_tready_back"}, 128'(cur_tready), 128'(1));
    end
    $display("frame %s len=%0d tuser=%0b record=%0b ev=%0d dr=%0d", tag, f.size(), tu, q,
             cur_stat_ev, cur_stat_dr);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tready"}, 128'(cur_tready), 128'(1));
    check({tag, "_ts_ready"}, 128'(cur_ts_ready), 128'(0));
    check({tag, "_valid"}, 128'(cur_mvalid), 128'(0));
    check({tag, "_outs"}, 128'({cur_mtype, cur_mseq, cur_mts}), 128'(0));
    check({tag, "_stats"}, 128'({cur_stat_ev, cur_stat_dr}), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q f, f2;
    logic [95:0] tsv;
    int len, sel_len;
    logic [15:0] et;
    logic [3:0] mt;
    logic tu;

    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    tick();

    f = make_frame(64, 16'h88F7, MSG_SYNC, 16'h1234);
    run_frame("sync", f, 1'b0, 96'h1_00000005_0000_0000, 0);
    f = make_frame(64, 16'h0800, 4'($urandom), 16'($urandom));
    run_frame("ipv4", f, 1'b0, {$urandom, $urandom, $urandom}, 0);
    f = make_frame(64, 16'h88F7, MSG_FOLLOW_UP, 16'h0042);
    run_frame("fup_mask_f", f, 1'b0, {$urandom, $urandom, $urandom}, 0);
    sel = 1'b1;
    tick();
    run_frame("fup_mask_10f", f, 1'b0, {$urandom, $urandom, $urandom}, 1);
    sel = 1'b0;
    tick();
    f = make_frame(64, 16'h88F7, MSG_SYNC, 16'h0777);
    run_frame("bad_tuser", f, 1'b1, {$urandom, $urandom, $urandom}, 0);
    f = make_frame(40, 16'h88F7, MSG_SYNC, 16'h0778);
    run_frame("short40", f, 1'b0, {$urandom, $urandom, $urandom}, 0);
    f = make_frame(45, 16'h88F7, MSG_DELAY_REQ, 16'h0A0B);
    run_frame("len45", f, 1'b0, {$urandom, $urandom, $urandom}, 0);
    f = make_frame(46, 16'h88F7, MSG_DELAY_REQ, 16'h0C0D);
    run_frame("len46", f, 1'b0, {$urandom, $urandom, $urandom}, 0);
    f = make_frame(100, 16'h88F7, MSG_PDELAY_RESP, 16'hBEEF);
    run_frame("len100", f, 1'b0, {$urandom, $urandom, $urandom}, 0);

    // Back-pressured record must hold and stall the next frame.
    m_ready = 1'b0;
    f  = make_frame(64, 16'h88F7, MSG_SYNC, 16'd1);
    f2 = make_frame(64, 16'h88F7, MSG_SYNC, 16'd2);
    tsv = {$urandom, $urandom, $urandom};
    run_frame("bp1", f, 1'b0, tsv, 0);
    tdata  = f2[0];
    tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold", 128'({cur_mvalid, cur_mtype, cur_mseq, cur_mts}),
            128'({1'b1, MSG_SYNC, 16'd1, tsv}));
      check("bp_stall", 128'({cur_tready, cur_ts_ready}), 128'(2'b00));
    end
    tvalid  = 1'b0;
    m_ready = 1'b1;
    tick();
    ev[0]++;
    check("bp1_release", 128'({cur_mvalid, cur_stat_ev}), 128'({1'b0, 16'(ev[0])}));
    run_frame("bp2", f2, 1'b0, {$urandom, $urandom, $urandom}, 0);

    for (int k = 0; k < 16; k++) begin
      sel_len = int'($urandom_range(0, 3));
      len = (sel_len == 0) ? int'($urandom_range(1, 14)) :
            (sel_len == 1) ? int'($urandom_range(40, 50)) : int'($urandom_range(55, 100));
      et  = ($urandom_range(0, 3) == 0) ? 16'h0800 : 16'h88F7;
      mt  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      tu  = ($urandom_range(0, 7) == 0);
      f = make_frame(len, et, mt, 16'($urandom));
      run_frame($sformatf("rand%0d", k), f, tu, {$urandom, $urandom, $urandom},
                int'($urandom_range(0, 3)));
    end

    f = make_frame(64, 16'h88F7, MSG_PDELAY_REQ, 16'h5A5A);
    run_frame("late_ts", f, 1'b0, {$urandom, $urandom, $urandom}, 20);

    // Reset in the middle of a frame; nothing of it may survive.
    f = make_frame(64, 16'h88F7, MSG_SYNC, 16'h1111);
    for (int i = 0; i < 30; i++) begin
      tdata  = f[i];
      tvalid = 1'b1;
      tick();
    end
    rst = 1'b1;
    tvalid = 1'b0;
    #1;
    ev = '{0, 0};
    dr = '{0, 0};
    check_idle("midreset");
    tick();
    rst = 1'b0;
    tick();
    f = make_frame(64, 16'h88F7, MSG_SYNC, 16'h2222);
    run_frame("post_reset", f, 1'b0, {$urandom, $urandom, $urandom}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
